squash_score_keeper: RTL and testbench

//  Upstream score/game controller for the squash display stage. Turns rally-result

---
 rtl/squash_pkg.sv | 13 +
 rtl/squash_event_edge.sv | 25 ++
 rtl/squash_score_keeper.sv | 128 ++++++++++++
 tb/tb_squash_score_keeper.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/squash_pkg.sv
// Game-level constants and state encoding shared by the squash score logic.
package squash_pkg;

  localparam int SCORE_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2,
    OVER   = 2'd3
  } state_t;

endpackage : squash_pkg

// File: rtl/squash_event_edge.sv
// Registered rising-edge detector for the three game inputs
// (bit 0 = start, bit 1 = rally_won, bit 2 = rally_lost).
// History resets to 0, so a level already high when reset releases
// produces one rising edge on the following cycle.
module squash_event_edge (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] levels,
  output logic [2:0] rise
);

  logic [2:0] levels_d1;

  // Capture one cycle of history and register the rising-edge strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      levels_d1 <= 3'b000;
      rise      <= 3'b000;
    end else begin
      levels_d1 <= levels;
      rise      <= levels & ~levels_d1;
    end
  end

endmodule : squash_event_edge

// File: rtl/squash_score_keeper.sv
// Score/game controller feeding the squash display stage. Converts rally
// result edges into a saturating score and a game-over flag with an
// end-of-game hold that returns to IDLE on its own.
// All outputs are registered; the FSM state is exposed on dbg_state.
module squash_score_keeper
  import squash_pkg::*;
#(
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_CYCLES = 200_000_000,
  parameter int HOLD_W      = 28
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               rally_won,
  input  logic               rally_lost,
  output logic [SCORE_W-1:0] rightpscore,
  output logic               gamestate,
  output logic               in_play,
  output logic               score_pulse,
  output state_t             dbg_state
);

  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [2:0] ev;
  logic       start_ev;
  logic       won_ev;
  logic       lost_ev;

  state_t              state;
  state_t              state_nxt;
  logic [SCORE_W-1:0]  score_nxt;
  logic [SCORE_W-1:0]  score_inc;
  logic                gamestate_nxt;
  logic                in_play_nxt;
  logic                score_pulse_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_cnt_nxt;

  squash_event_edge u_edge (
    .clock  (clock),
    .reset  (reset),
    .levels ({rally_lost, rally_won, start}),
    .rise   (ev)
  );

  assign start_ev  = ev[0];
  assign won_ev    = ev[1];
  // A lost rally never changes score or state; it is decoded for clarity only.
  assign lost_ev   = ev[2];
  assign score_inc = rightpscore + 1'b1;
  assign dbg_state = state;

  // State, score, hold counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rightpscore <= '0;
      gamestate   <= 1'b0;
      in_play     <= 1'b0;
      score_pulse <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      rightpscore <= score_nxt;
      gamestate   <= gamestate_nxt;
      in_play     <= in_play_nxt;
      score_pulse <= score_pulse_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

  // Next-state decision; won beats lost when both arrive together.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ev) state_nxt = PLAY;
      PLAY:    if (won_ev) state_nxt = SCORED;
               else if (lost_ev) state_nxt = PLAY;
      SCORED:  state_nxt = (score_inc == WIN_S) ? OVER : PLAY;
      OVER:    if (start_ev) state_nxt = PLAY;
               else if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of score, game-over flag, hold counter and strobes.
  // in_play and score_pulse are derived from the next state so they line
  // up with PLAY and SCORED while still coming straight from flops.
  always_comb begin
    score_nxt     = rightpscore;
    gamestate_nxt = gamestate;
    hold_cnt_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (start_ev) begin
          score_nxt     = '0;
          gamestate_nxt = 1'b0;
        end
      end
      SCORED: begin
        score_nxt = score_inc;
        if (score_inc == WIN_S) begin
          gamestate_nxt = 1'b1;
          hold_cnt_nxt  = '0;
        end
      end
      OVER: begin
        if (start_ev) begin
          score_nxt     = '0;
          gamestate_nxt = 1'b0;
          hold_cnt_nxt  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          gamestate_nxt = 1'b0;
          hold_cnt_nxt  = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: ;
    endcase
    in_play_nxt     = (state_nxt == PLAY);
    score_pulse_nxt = (state_nxt == SCORED);
  end

endmodule : squash_score_keeper

// File: tb/tb_squash_score_keeper.sv
// Directed bench for squash_score_keeper with HOLD_CYCLES=8, WIN_SCORE=3.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, and a negedge monitor checks each score after its strobe.
module tb_squash_score_keeper;
  import squash_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       rally_won;
  logic       rally_lost;
  logic [1:0] rightpscore;
  logic       gamestate;
  logic       in_play;
  logic       score_pulse;
  state_t     dbg_state;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  logic [1:0] exp_q[$];
  logic       pulse_d = 1'b0;

  squash_score_keeper #(
    .WIN_SCORE   (3),
    .HOLD_CYCLES (8),
    .HOLD_W      (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .rally_won   (rally_won),
    .rally_lost  (rally_lost),
    .rightpscore (rightpscore),
    .gamestate   (gamestate),
    .in_play     (in_play),
    .score_pulse (score_pulse),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rally_won pulse; returns when the new score is visible.
  task automatic win(input logic [1:0] next_score);
    exp_q.push_back(next_score);
    rally_won = 1'b1;
    step(1);
    rally_won = 1'b0;
    step(2);
  endtask

  task automatic press_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
  endtask

  // Scoreboard: the cycle after each strobe the score must match the queue.
  always @(negedge clock) begin
    if (pulse_d) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL sb_unexpected_pulse: observed=%0d expected=none", rightpscore);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        assert (rightpscore === e) else begin
          bad++;
          $error("FAIL sb_score: observed=%0d expected=%0d", rightpscore, e);
        end
      end
    end
    if (score_pulse === 1'b1) pulse_cnt++;
    pulse_d = (score_pulse === 1'b1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; rally_won = 1'b0; rally_lost = 1'b0;
    step(3);
    reset = 1'b0;

    // 1: reset and idle
    step(10);
    check("rst_score", rightpscore, 0);
    check("rst_gamestate", gamestate, 0);
    check("rst_in_play", in_play, 0);
    check("rst_pulse", score_pulse, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // 2: start, then first win with latency checks
    press_start();
    check("start_in_play", in_play, 1);
    check("start_score", rightpscore, 0);
    exp_q.push_back(2'd1);
    rally_won = 1'b1;
    step(1);
    rally_won = 1'b0;
    check("won_ev_no_pulse_yet", score_pulse, 0);
    step(1);
    check("scored_pulse", score_pulse, 1);
    check("scored_state", 32'(dbg_state), 32'(SCORED));
    check("scored_score_old", rightpscore, 0);
    step(1);
    check("win1_score", rightpscore, 1);
    check("win1_pulse_low", score_pulse, 0);
    check("win1_in_play", in_play, 1);

    // 3: rally_lost at score 1
    rally_lost = 1'b1;
    step(1);
    rally_lost = 1'b0;
    step(1);
    check("lost_no_pulse", score_pulse, 0);
    step(1);
    check("lost_score", rightpscore, 1);
    check("lost_in_play", in_play, 1);
    check("lost_pulse_cnt", pulse_cnt, 1);

    win(2'd2);
    check("win2_score", rightpscore, 2);
    check("win2_gamestate", gamestate, 0);
    win(2'd3);
    check("win3_score", rightpscore, 3);
    check("win3_gamestate", gamestate, 1);
    check("win3_in_play", in_play, 0);
    check("win3_pulse_cnt", pulse_cnt, 3);
    step(7);
    check("hold_last_gamestate", gamestate, 1);
    step(1);
    check("hold_done_gamestate", gamestate, 0);
    check("hold_done_score", rightpscore, 3);
    check("hold_done_state", 32'(dbg_state), 32'(IDLE));

    // 4: won and lost together at score 0
    press_start();
    check("g2_score", rightpscore, 0);
    check("g2_gamestate", gamestate, 0);
    exp_q.push_back(2'd1);
    rally_won = 1'b1; rally_lost = 1'b1;
    step(1);
    rally_won = 1'b0; rally_lost = 1'b0;
    step(2);
    check("both_score", rightpscore, 1);
    step(3);
    check("both_pulse_cnt", pulse_cnt, 4);

    // 5: restart from OVER at hold count 4
    win(2'd2);
    win(2'd3);
    check("g2_over_gamestate", gamestate, 1);
    step(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("restart_pre_gamestate", gamestate, 1);
    step(1);
    check("restart_gamestate", gamestate, 0);
    check("restart_score", rightpscore, 0);
    check("restart_in_play", in_play, 1);
    check("restart_state", 32'(dbg_state), 32'(PLAY));

    // 6: reset mid-game, held rally_won must not score
    win(2'd1);
    win(2'd2);
    check("pre_reset_score", rightpscore, 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_score", rightpscore, 0);
    check("midrst_in_play", in_play, 0);
    rally_won = 1'b1;
    step(5);
    check("held_idle_score", rightpscore, 0);
    press_start();
    step(4);
    check("held_play_score", rightpscore, 0);
    check("held_play_in_play", in_play, 1);
    check("held_pulse_cnt", pulse_cnt, 8);
    rally_won = 1'b0;
    step(1);
    win(2'd1);
    check("fresh_score", rightpscore, 1);
    step(2);
    check("final_pulse_cnt", pulse_cnt, 9);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_squash_score_keeper
